// File: rtl/monostable_domain_cross_sync.sv
// Receive half of a single-bit event crossing: synchronizes a level-coded event into clk
// and emits one registered pulse per event. Define MONOSTABLE_DOMAIN_CROSS_TOGGLE_IN_EN for toggle mode.
module monostable_domain_cross_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic overrun
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic                   evt;
  logic                   pending;
  logic                   chain_diff;

  // NOTE: every register is cleared by the async reset so an in-flight event is dropped at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep each stage sampling the previous stage's old value.
      sync <= {sync[SYNC_STAGES-2:0], in};
      hist <= sync[SYNC_STAGES-1];
    end
  end

`ifdef MONOSTABLE_DOMAIN_CROSS_TOGGLE_IN_EN
  assign evt     = sync[SYNC_STAGES-1] ^ hist;
  assign pending = sync[1] ^ hist;
`else
  assign evt     = sync[SYNC_STAGES-1] & ~hist;
  assign pending = sync[1] & ~hist;
`endif

  // A new change entering the chain while an earlier one has not been reported is an overrun.
  assign chain_diff = sync[0] ^ sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      // Masking with the previous out keeps merged back-to-back toggles to a single-cycle pulse.
      out     <= evt & ~out;
      overrun <= overrun | (chain_diff & pending);
    end
  end

endmodule

// File: tb/tb_monostable_domain_cross_sync.sv
// Self-checking bench for monostable_domain_cross_sync: cycle vectors plus reset/latency sequences.
module tb_monostable_domain_cross_sync;

`ifdef MONOSTABLE_DOMAIN_CROSS_TOGGLE_IN_EN
  localparam bit TOGGLE = 1'b1;
`else
  localparam bit TOGGLE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in  = 1'b0;
  logic out;
  logic overrun;

  int checks = 0;
  int errors = 0;

  monostable_domain_cross_sync #(.SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .out     (out),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic in;
    logic out;
    logic ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic i, input logic o, input logic v);
    vec_t r;
    r.in = i; r.out = o; r.ovr = v;
    vecs.push_back(r);
  endtask

  // Runs n cycles sampling 1 time unit after each rising edge; counts pulses and flags wide ones.
  task automatic run(input int n, output int pulses, output int wide);
    logic prev;
    prev   = out;
    pulses = 0;
    wide   = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (out === 1'b1 && prev !== 1'b1) pulses++;
      if (out === 1'b1 && prev === 1'b1) wide++;
      prev = out;
    end
  endtask

  task automatic do_reset(input logic in_val);
    @(negedge clk);
    rst = 1'b0;
    in  = in_val;
    #1;
    check("reset_out_async", out, 0);
    check("reset_ovr_async", overrun, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_in(input logic v);
    @(negedge clk);
    in = v;
  endtask

  initial begin
    int p, w, first;

    // Reset and idle.
    do_reset(1'b0);
    run(20, p, w);
    check("idle_pulses", p, 0);
    check("idle_ovr", overrun, 0);

    // Vector i drives in before edge i+1 and checks outputs just after that edge.
    if (!TOGGLE) begin
      for (int r = 0; r < 2; r++) begin
        add(1, 0, 0); add(1, 0, 0); add(1, 1, 0); add(1, 0, 0);
        add(0, 0, 0); add(0, 0, 0); add(0, 0, 0); add(0, 0, 0);
      end
      // One-cycle pulse: violates the source rule, still at most one out pulse, sets overrun.
      add(1, 0, 0); add(0, 0, 0); add(0, 1, 1); add(0, 0, 1); add(0, 0, 1); add(0, 0, 1);
    end else begin
      for (int t = 0; t < 4; t++) begin
        add(~t[0], 0, 0); add(~t[0], 0, 0); add(~t[0], 1, 0);
        add(~t[0], 0, 0); add(~t[0], 0, 0);
      end
      // Two toggles one cycle apart: one merged pulse, overrun sets.
      add(1, 0, 0); add(0, 0, 0); add(0, 1, 1); add(0, 0, 1); add(0, 0, 1); add(0, 0, 1);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      in = vecs[i].in;
      @(posedge clk); #1;
      check($sformatf("vec%0d_out", i), out, vecs[i].out);
      check($sformatf("vec%0d_ovr", i), overrun, vecs[i].ovr);
    end

    // Overrun is sticky until reset.
    run(10, p, w);
    check("ovr_sticky", overrun, 1);
    do_reset(1'b0);
    run(5, p, w);
    check("ovr_cleared", overrun, 0);

    // Level held 50 cycles: one pulse on the rise; the fall pulses only in toggle mode.
    set_in(1'b1);
    run(50, p, w);
    check("level_rise_pulses", p, 1);
    check("level_rise_wide", w, 0);
    set_in(1'b0);
    run(10, p, w);
    check("level_fall_pulses", p, TOGGLE ? 1 : 0);
    check("level_ovr", overrun, 0);

    // Latency: pulse appears on edge 3 after driving before edge 1.
    set_in(~in);
    first = 0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      if (out === 1'b1 && first == 0) first = e;
    end
    check("latency_edge", first, 3);
    set_in(1'b0);
    run(8, p, w);

    // Release with in already high counts as one event.
    do_reset(1'b1);
    run(10, p, w);
    check("release_high_pulses", p, 1);
    check("release_high_wide", w, 0);

    // Reset mid-flight: event discarded, nothing after release.
    do_reset(1'b0);
    run(4, p, w);
    set_in(1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    in  = 1'b0;
    #1;
    check("midflight_out_async", out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run(12, p, w);
    check("midflight_pulses", p, 0);
    check("midflight_ovr", overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
